wrapper_sha256_message_padder: RTL and testbench
================================================

WRAPPER_SHA256_MESSAGE_PADDER -- requirements
Module: wrapper_sha256_message_padder

Interface
REQ-001 SHALL have parameter LENWIDTH, default 64, the width of the message bit-length field and cfg_size.
REQ-002 hclk  input  1  clock; all state updates occur on its rising edge.
REQ-003 hresetn  input  1  asynchronous active-low reset.
REQ-004 word_data  input  32  message word, first message byte in bits 31:24.
REQ-005 word_bytes  input  2  valid bytes minus one on the last word (0=1 byte .. 3=4 bytes); ignored when word_last=0.
REQ-006 word_last  input  1  marks the final word of a message.
REQ-007 word_valid  input  1  word channel valid.
REQ-008 word_ready  output  1  word channel ready.
REQ-009 packet_data  output  512  padded SHA-256 block; word 0 in bits 511:480.
REQ-010 packet_data_last  output  1  marks the final block of a message.
REQ-011 packet_data_valid  output  1  block channel valid.
REQ-012 packet_data_ready  input  1  block channel ready from the hashing engine.
REQ-013 cfg_size  output  LENWIDTH  message length in bits.
REQ-014 cfg_scheme  output  2  constant 2'd0.
REQ-015 cfg_last  output  1  constant 1.
REQ-016 cfg_valid  output  1  config channel valid.
REQ-017 cfg_ready  input  1  config channel ready.

Function
REQ-018 SHALL implement states FILL, EMIT_DATA, EMIT_FINAL and EMIT_EXTRA.
REQ-019 FILL: word_ready=1; each accepted word goes into block slot widx (0..15); widx increments; byte counter adds 4, or word_bytes+1 on the last word.
REQ-020 SHALL move to EMIT_DATA when a non-last word is accepted at widx=15; blocks are presented with packet_data_last=0 on the following cycle.
REQ-021 On the last word with b valid bytes, SHALL keep the top b bytes, zero the rest and place 0x80 in byte b if b<4; if b=4, 0x80 goes in byte 0 of the next slot, or of the extra block if widx=15.
REQ-022 If 4*widx+b+1 <= 56, SHALL write the bit length into slots 14..15 (big-endian, zero-extended to 64 bits) and go to EMIT_FINAL with last=1; otherwise go to EMIT_DATA-like EMIT_FINAL with last=0, followed by EMIT_EXTRA.
REQ-023 EMIT_EXTRA block SHALL be all zero except an optional 0x80 at word 0 (REQ-021) and the length in slots 14..15; packet_data_last=1.
REQ-024 In EMIT_* states: word_ready=0; packet_data and packet_data_last SHALL stay stable while packet_data_valid=1 and packet_data_ready=0.
REQ-025 On block handshake, SHALL clear the buffer and set widx=0 in the same cycle; return to FILL, or advance to EMIT_EXTRA.
REQ-026 cfg_valid SHALL assert the cycle after the last word is accepted, with cfg_size=8*byte count; it SHALL hold until cfg_ready, independently of the block channel.
REQ-027 FILL SHALL NOT accept the first word of a new message until the previous message's final block and cfg have both been handshaken; byte counter then clears.
REQ-028 Byte counter SHALL be LENWIDTH-3 bits and wrap modulo 2^(LENWIDTH-3); zero-length messages are unsupported.
REQ-029 Block and cfg handshakes in the same cycle SHALL both complete.

Reset
REQ-030 On hresetn low, SHALL enter FILL with widx=0, a cleared buffer and counter, packet_data=0, packet_data_valid=0, packet_data_last=0, cfg_valid=0 and cfg_size=0; word_ready=1 after reset releases.
REQ-031 Reset mid-message SHALL discard partial data; the next accepted word SHALL start a new message at slot 0.

Verification
REQ-032 "abc": one word 0x61626300, bytes=2, last -> block word0=0x61626380, words1-14=0, word15=0x00000018, last=1; cfg_size=24.
REQ-033 56-byte message (14 words, last bytes=3) -> block1 words14/15=0x80000000/0, last=0; block2 all zero except word15=0x000001C0, last=1; cfg_size=448.
REQ-034 64-byte message (16 words) -> block1 data, last=0; block2 word0=0x80000000, word15=0x00000200, last=1.
REQ-035 packet_data_ready held low 5 cycles during a block -> valid held and data stable; word_ready=0; transfer completes on the first ready cycle.
REQ-036 cfg_ready low after final block handshake -> word_ready stays 0 until cfg handshake, then returns to 1.
REQ-037 hresetn pulsed after 7 words -> all outputs at reset values; a following "abc" message yields exactly the REQ-032 result.

Source files
------------

// File: rtl/wrapper_sha256_message_padder.sv
// ---------------------------------------------------------------------------
// wrapper_sha256_message_padder
//
// Packs a byte stream, delivered as 32-bit big-endian words, into 512-bit
// SHA-256 blocks and applies the standard padding: a 0x80 byte after the
// message, zero fill, and the 64-bit message bit length in the last two
// words of the final block. When the padding does not fit, an extra
// block is emitted. A separate config channel reports the message bit
// length once per message.
//
// Ports
//   hclk, hresetn             clock, asynchronous active-low reset
//   word_data/bytes/last      message word in (byte 0 in [31:24]); bytes is
//   word_valid/ready          valid-bytes-minus-one on the last word
//   packet_data[511:0]        padded block out, word 0 in [511:480]
//   packet_data_last          final block of the message
//   packet_data_valid/ready   block channel handshake
//   cfg_size[LENWIDTH-1:0]    message length in bits
//   cfg_scheme, cfg_last      constants (2'd0, 1)
//   cfg_valid/ready           config channel handshake
// ---------------------------------------------------------------------------
module wrapper_sha256_message_padder #(
  parameter int LENWIDTH = 64
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic [31:0]         word_data,
  input  logic [1:0]          word_bytes,
  input  logic                word_last,
  input  logic                word_valid,
  output logic                word_ready,
  output logic [511:0]        packet_data,
  output logic                packet_data_last,
  output logic                packet_data_valid,
  input  logic                packet_data_ready,
  output logic [LENWIDTH-1:0] cfg_size,
  output logic [1:0]          cfg_scheme,
  output logic                cfg_last,
  output logic                cfg_valid,
  input  logic                cfg_ready
);

  localparam int CW = LENWIDTH - 3;

  typedef enum logic [1:0] {
    FILL       = 2'd0,
    EMIT_DATA  = 2'd1,
    EMIT_FINAL = 2'd2,
    EMIT_EXTRA = 2'd3
  } state_t;

  state_t              r_state;
  logic [31:0]         r_buf [16];
  logic [3:0]          r_widx;
  logic [CW-1:0]       r_bytes;
  logic [63:0]         r_len;
  logic                r_extra_80;
  logic                r_pvalid;
  logic                r_plast;
  logic                r_cfg_valid;
  logic [LENWIDTH-1:0] r_cfg_size;

  logic                w_accept;
  logic                w_blk_hs;
  logic [2:0]          w_inc;
  logic [CW-1:0]       w_bytes_next;
  logic [LENWIDTH-1:0] w_bitlen;
  logic [63:0]         w_len64;
  logic [31:0]         w_last_word;
  logic [6:0]          w_pad_end;
  logic                w_fits;

  // A new message may only start once the previous message's cfg has been
  // taken; the final block is already gone because we are back in FILL.
  assign word_ready   = (r_state == FILL) && !r_cfg_valid;
  assign w_accept     = word_ready && word_valid;
  assign w_blk_hs     = r_pvalid && packet_data_ready;

  assign w_inc        = word_last ? ({1'b0, word_bytes} + 3'd1) : 3'd4;
  assign w_bytes_next = r_bytes + CW'(w_inc);
  assign w_bitlen     = {w_bytes_next, 3'b000};
  assign w_len64      = 64'(w_bitlen);

  // Byte offset just past the 0x80 marker; the 8 length bytes fit in this
  // block only if the marker ends at or before byte 56.
  assign w_pad_end    = {1'b0, r_widx, 2'b00} + {5'd0, word_bytes} + 7'd2;
  assign w_fits       = (w_pad_end <= 7'd56);

  // Keep the valid bytes of the last word and append the 0x80 marker when
  // it lands inside this word.
  always_comb begin
    w_last_word = word_data;
    case (word_bytes)
      2'd0:    w_last_word = {word_data[31:24], 8'h80, 16'h0000};
      2'd1:    w_last_word = {word_data[31:16], 8'h80, 8'h00};
      2'd2:    w_last_word = {word_data[31:8], 8'h80};
      default: w_last_word = word_data;
    endcase
  end

  always_comb begin
    packet_data = '0;
    for (int i = 0; i < 16; i++) begin
      packet_data[511-32*i -: 32] = r_buf[i];
    end
  end

  assign packet_data_valid = r_pvalid;
  assign packet_data_last  = r_plast;
  assign cfg_valid         = r_cfg_valid;
  assign cfg_size          = r_cfg_size;
  assign cfg_scheme        = 2'd0;
  assign cfg_last          = 1'b1;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= FILL;
      r_widx      <= '0;
      r_bytes     <= '0;
      r_len       <= '0;
      r_extra_80  <= 1'b0;
      r_pvalid    <= 1'b0;
      r_plast     <= 1'b0;
      r_cfg_valid <= 1'b0;
      r_cfg_size  <= '0;
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
    end else begin
      if (r_cfg_valid && cfg_ready) r_cfg_valid <= 1'b0;

      // Any block handshake empties the buffer; EMIT_FINAL may then
      // immediately reload it with the extra block below.
      if (r_state != FILL && w_blk_hs) begin
        r_widx <= '0;
        for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      end

      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_widx <= r_widx + 4'd1;
            if (!word_last) begin
              r_buf[r_widx] <= word_data;
              r_bytes       <= w_bytes_next;
              if (r_widx == 4'd15) begin
                r_state  <= EMIT_DATA;
                r_pvalid <= 1'b1;
                r_plast  <= 1'b0;
              end
            end else begin
              r_buf[r_widx] <= w_last_word;
              // Full last word: the marker starts the next slot, or the
              // extra block when this was the final slot.
              if (word_bytes == 2'd3) begin
                if (r_widx == 4'd15) r_extra_80 <= 1'b1;
                else r_buf[r_widx + 4'd1] <= 32'h8000_0000;
              end
              if (w_fits) begin
                r_buf[14] <= w_len64[63:32];
                r_buf[15] <= w_len64[31:0];
              end
              r_len       <= w_len64;
              r_bytes     <= '0;
              r_cfg_valid <= 1'b1;
              r_cfg_size  <= w_bitlen;
              r_state     <= EMIT_FINAL;
              r_pvalid    <= 1'b1;
              r_plast     <= w_fits;
            end
          end
        end

        EMIT_DATA: begin
          if (w_blk_hs) begin
            r_pvalid <= 1'b0;
            r_state  <= FILL;
          end
        end

        EMIT_FINAL: begin
          if (w_blk_hs) begin
            if (r_plast) begin
              r_pvalid <= 1'b0;
              r_plast  <= 1'b0;
              r_state  <= FILL;
            end else begin
              r_buf[0]   <= r_extra_80 ? 32'h8000_0000 : 32'h0000_0000;
              r_buf[14]  <= r_len[63:32];
              r_buf[15]  <= r_len[31:0];
              r_extra_80 <= 1'b0;
              r_plast    <= 1'b1;
              r_state    <= EMIT_EXTRA;
            end
          end
        end

        EMIT_EXTRA: begin
          if (w_blk_hs) begin
            r_pvalid <= 1'b0;
            r_plast  <= 1'b0;
            r_state  <= FILL;
          end
        end

        default: r_state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_wrapper_sha256_message_padder.sv
module tb_wrapper_sha256_message_padder;

  localparam int LENWIDTH = 64;

  logic                hclk = 1'b0;
  logic                hresetn = 1'b0;
  logic [31:0]         word_data = '0;
  logic [1:0]          word_bytes = '0;
  logic                word_last = 1'b0;
  logic                word_valid = 1'b0;
  logic                word_ready;
  logic [511:0]        packet_data;
  logic                packet_data_last;
  logic                packet_data_valid;
  logic                packet_data_ready = 1'b0;
  logic [LENWIDTH-1:0] cfg_size;
  logic [1:0]          cfg_scheme;
  logic                cfg_last;
  logic                cfg_valid;
  logic                cfg_ready = 1'b0;

  wrapper_sha256_message_padder #(.LENWIDTH(LENWIDTH)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .word_data(word_data), .word_bytes(word_bytes), .word_last(word_last),
    .word_valid(word_valid), .word_ready(word_ready),
    .packet_data(packet_data), .packet_data_last(packet_data_last),
    .packet_data_valid(packet_data_valid), .packet_data_ready(packet_data_ready),
    .cfg_size(cfg_size), .cfg_scheme(cfg_scheme), .cfg_last(cfg_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    int          nw;     // words sent
    int          lb;     // word_bytes on last word
    int          nblk;   // expected block count
    int          cfg;    // expected cfg_size
    int          pblk;   // block holding the 0x80 marker
    int          pword;  // word holding the 0x80 marker
    logic [31:0] pval;   // expected value of that word
  } vec_t;

  vec_t tbl [8];

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0]   msgb [0:255];
  logic [7:0]   junk;
  logic [511:0] got_blk [0:3];
  logic         got_last [0:3];
  int           got_n;
  logic [63:0]  got_cfg;
  int           got_cfgn;
  int           stall_cycles;
  logic         bad_emit_ready, bad_stall, bad_cfgwait, timeout;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] mk_word(input int wi, input int lb);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[31-8*b -: 8] = (b <= lb) ? msgb[4*wi+b] : junk;
    return w;
  endfunction

  // Reference SHA-256 padding of the first L bytes of msgb, block k.
  function automatic logic [511:0] exp_blk(input int L, input int k);
    logic [511:0] r;
    logic [7:0]   b;
    logic [63:0]  bl;
    int           n, nb;
    nb = (L + 8) / 64 + 1;
    bl = 64'(L) * 64'd8;
    for (int w = 0; w < 64; w++) begin
      n = 64*k + w;
      if (n < L)                b = msgb[n];
      else if (n == L)          b = 8'h80;
      else if (n >= 64*nb - 8)  b = bl[8*(64*nb-1-n) +: 8];
      else                      b = 8'h00;
      r[511-8*w -: 8] = b;
    end
    return r;
  endfunction

  task automatic run_msg(input int nw, input int lb, input int pr_delay, input int cf_delay);
    int wi, cyc, scnt, ccnt;
    bit bdone, cdone, holding;
    logic [511:0] held;
    logic held_last;
    wi = 0; cyc = 0; scnt = 0; ccnt = 0; bdone = 0; cdone = 0; holding = 0;
    held = '0; held_last = 1'b0;
    got_n = 0; got_cfgn = 0; got_cfg = '0; stall_cycles = 0;
    bad_emit_ready = 0; bad_stall = 0; bad_cfgwait = 0; timeout = 0;
    while (!(bdone && cdone)) begin
      @(negedge hclk);
      cyc++;
      if (cyc > 3000) begin timeout = 1; break; end
      word_valid = (wi < nw);
      word_last  = (wi == nw - 1);
      word_bytes = (wi == nw - 1) ? 2'(lb) : 2'd0;
      word_data  = (wi < nw) ? mk_word(wi, (wi == nw - 1) ? lb : 3) : 32'h0;
      if (packet_data_valid) begin
        if (word_ready) bad_emit_ready = 1;
        if (holding && (packet_data !== held || packet_data_last !== held_last)) bad_stall = 1;
        if (scnt < pr_delay) begin
          packet_data_ready = 1'b0;
          scnt++; stall_cycles++;
          held = packet_data; held_last = packet_data_last; holding = 1;
        end else begin
          packet_data_ready = 1'b1;
          scnt = 0; holding = 0;
          if (got_n < 4) begin
            got_blk[got_n] = packet_data;
            got_last[got_n] = packet_data_last;
          end
          got_n++;
          if (packet_data_last) bdone = 1;
        end
      end else begin
        packet_data_ready = 1'b0;
        holding = 0;
      end
      if (cfg_valid) begin
        if (word_ready) bad_cfgwait = 1;
        if (ccnt < cf_delay) begin
          cfg_ready = 1'b0; ccnt++;
        end else begin
          cfg_ready = 1'b1; got_cfg = cfg_size; got_cfgn++; cdone = 1;
        end
      end else begin
        cfg_ready = 1'b0;
      end
      if (word_valid && word_ready) wi++;
    end
    @(posedge hclk);
    #1;
    word_valid = 1'b0; word_last = 1'b0; packet_data_ready = 1'b0; cfg_ready = 1'b0;
  endtask

  task automatic verify_msg(input string nm, input int nw, input int lb, input int nblk, input int cfg);
    int L;
    L = 4*(nw-1) + lb + 1;
    chk({nm, "_timeout"}, 512'(timeout), 512'(0));
    chk({nm, "_nblk"}, 512'(got_n), 512'(nblk));
    chk({nm, "_cfg"}, 512'(got_cfg), 512'(cfg));
    for (int k = 0; k < got_n && k < 4; k++) begin
      chk($sformatf("%s_blk%0d", nm, k), got_blk[k], exp_blk(L, k));
      chk($sformatf("%s_last%0d", nm, k), 512'(got_last[k]), 512'(k == nblk - 1));
    end
    chk({nm, "_emit_wready"}, 512'(bad_emit_ready), 512'(0));
    chk({nm, "_cfg_wready"}, 512'(bad_cfgwait), 512'(0));
    chk({nm, "_ready_after"}, 512'(word_ready), 512'(1));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_pdata"}, packet_data, 512'(0));
    chk({nm, "_pvalid"}, 512'(packet_data_valid), 512'(0));
    chk({nm, "_plast"}, 512'(packet_data_last), 512'(0));
    chk({nm, "_cvalid"}, 512'(cfg_valid), 512'(0));
    chk({nm, "_csize"}, 512'(cfg_size), 512'(0));
  endtask

  task automatic load_pattern();
    for (int n = 0; n < 256; n++) msgb[n] = 8'(n + 1);
    junk = 8'hEE;
  endtask

  task automatic load_abc();
    load_pattern();
    msgb[0] = 8'h61; msgb[1] = 8'h62; msgb[2] = 8'h63;
    junk = 8'h00;
  endtask

  logic [511:0] abc_blk;

  initial begin
    load_pattern();
    //           nw lb nblk cfg  pblk pword pval
    tbl[0] = '{ 1, 2, 1,  24, 0, 0,  32'h01020380};
    tbl[1] = '{ 1, 3, 1,  32, 0, 1,  32'h80000000};
    tbl[2] = '{14, 3, 2, 448, 0, 14, 32'h80000000};
    tbl[3] = '{14, 2, 1, 440, 0, 13, 32'h35363780};
    tbl[4] = '{16, 3, 2, 512, 1, 0,  32'h80000000};
    tbl[5] = '{15, 0, 2, 456, 0, 14, 32'h39800000};
    tbl[6] = '{17, 1, 2, 528, 1, 0,  32'h41428000};
    tbl[7] = '{13, 3, 1, 416, 0, 13, 32'h80000000};

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;

    // Reset state
    #12;
    check_reset_outputs("rst");
    chk("rst_scheme", 512'(cfg_scheme), 512'(0));
    chk("rst_cfglast", 512'(cfg_last), 512'(1));
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("rst_wready", 512'(word_ready), 512'(1));

    // Table-driven messages
    for (int i = 0; i < 8; i++) begin
      run_msg(tbl[i].nw, tbl[i].lb, 0, 0);
      verify_msg($sformatf("t%0d", i), tbl[i].nw, tbl[i].lb, tbl[i].nblk, tbl[i].cfg);
      if (tbl[i].pblk < 4)
        chk($sformatf("t%0d_padword", i),
            512'(got_blk[tbl[i].pblk][511-32*tbl[i].pword -: 32]), 512'(tbl[i].pval));
      if (tbl[i].nblk - 1 < 4)
        chk($sformatf("t%0d_lenword", i),
            512'(got_blk[tbl[i].nblk-1][31:0]), 512'(tbl[i].cfg));
    end

    // "abc" known-answer block
    load_abc();
    run_msg(1, 2, 0, 0);
    verify_msg("abc", 1, 2, 1, 24);
    chk("abc_const", got_blk[0], abc_blk);

    // Block channel backpressure: 5 stall cycles per block
    load_pattern();
    run_msg(16, 3, 5, 0);
    verify_msg("bp", 16, 3, 2, 512);
    chk("bp_stable", 512'(bad_stall), 512'(0));
    chk("bp_stalls", 512'(stall_cycles), 512'(10));

    // cfg_ready held off well past the final block
    load_abc();
    run_msg(1, 2, 0, 8);
    verify_msg("cfgwait", 1, 2, 1, 24);

    // Reset pulsed after 7 words of a message
    load_pattern();
    for (int i = 0; i < 7; i++) begin
      @(negedge hclk);
      word_valid = 1'b1; word_last = 1'b0; word_bytes = 2'd0;
      word_data = mk_word(i, 3);
    end
    @(negedge hclk);
    word_valid = 1'b0;
    #2 hresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    chk("midrst_wready", 512'(word_ready), 512'(1));
    load_abc();
    run_msg(1, 2, 0, 0);
    verify_msg("abc2", 1, 2, 1, 24);
    chk("abc2_const", got_blk[0], abc_blk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
